// File: rtl/draw_layer_mux.sv
// Priority multiplexer for stacked draw layers: picks the lowest-index opaque
// requester per pixel and tracks per-frame layer collisions.
module draw_layer_mux #(
   parameter int NUM_LAYERS = 4,
   parameter int DATA_W     = 6,
   parameter int TRANSP_EN  = 1,
   parameter logic [DATA_W-1:0] TRANSP_VAL = DATA_W'(6'h3F),
   localparam int ID_W = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pix_valid,
   input  logic                         frame_start,
   input  logic [NUM_LAYERS-1:0]        layer_req,
   input  logic [NUM_LAYERS*DATA_W-1:0] layer_data,
   output logic [DATA_W-1:0]            data,
   output logic                         draw,
   output logic                         out_valid,
   output logic [ID_W-1:0]              layer_id,
   output logic                         coll_flag,
   output logic [NUM_LAYERS-1:0]        hit_mask,
   output logic [NUM_LAYERS-1:0]        last_hits
);

   logic [NUM_LAYERS-1:0] w_elig;
   logic [ID_W-1:0]       w_winId;
   logic [DATA_W-1:0]     w_winData;
   logic                  w_any;
   logic                  w_coll;

   logic [DATA_W-1:0]     r_data;
   logic                  r_draw;
   logic                  r_outValid;
   logic [ID_W-1:0]       r_layerId;
   logic                  r_collFlag;
   logic [NUM_LAYERS-1:0] r_hitMask;
   logic [NUM_LAYERS-1:0] r_lastHits;

   // Scanning from the top index down lets the lowest eligible index win.
   always_comb begin
      w_elig    = '0;
      w_winId   = '0;
      w_winData = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_elig[i] = layer_req[i] &&
                     !((TRANSP_EN != 0) && (layer_data[i*DATA_W +: DATA_W] == TRANSP_VAL));
      end
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_winId   = ID_W'(i);
            w_winData = layer_data[i*DATA_W +: DATA_W];
         end
      end
      w_any  = |w_elig;
      w_coll = (w_elig & (w_elig - 1'b1)) != '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_draw     <= 1'b0;
         r_outValid <= 1'b0;
         r_layerId  <= '0;
         r_collFlag <= 1'b0;
         r_hitMask  <= '0;
         r_lastHits <= '0;
      end else begin
         r_outValid <= pix_valid;
         r_draw     <= pix_valid && w_any;
         if (pix_valid && w_any) begin
            r_data    <= w_winData;
            r_layerId <= w_winId;
         end
         // A frame boundary snapshots only the prior frame; this cycle's hits seed the new one.
         if (frame_start) begin
            r_lastHits <= r_hitMask;
            r_hitMask  <= (pix_valid && w_coll) ? w_elig : '0;
            r_collFlag <= pix_valid && w_coll;
         end else if (pix_valid && w_coll) begin
            r_hitMask  <= r_hitMask | w_elig;
            r_collFlag <= 1'b1;
         end
      end
   end

   assign data      = r_data;
   assign draw      = r_draw;
   assign out_valid = r_outValid;
   assign layer_id  = r_layerId;
   assign coll_flag = r_collFlag;
   assign hit_mask  = r_hitMask;
   assign last_hits = r_lastHits;

endmodule

// File: tb/tb_draw_layer_mux.sv
// Bench for draw_layer_mux: a transparency-enabled and a transparency-disabled
// instance checked each cycle against a behavioural model plus literal vectors.
module tb_draw_layer_mux;

   typedef struct {
      logic [5:0] data;
      logic       draw;
      logic       ov;
      logic [1:0] id;
      logic       coll;
      logic [3:0] hm;
      logic [3:0] lh;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        pixValid;
   logic        frameStart;
   logic [3:0]  layerReq;
   logic [23:0] layerData;

   logic [5:0] dataA, dataB;
   logic       drawA, drawB, ovA, ovB, collA, collB;
   logic [1:0] idA, idB;
   logic [3:0] hmA, hmB, lhA, lhB;

   exp_t model [2];
   int   numChecks = 0;
   int   numPassed = 0;

   draw_layer_mux #(.NUM_LAYERS(4), .DATA_W(6), .TRANSP_EN(1), .TRANSP_VAL(6'h3F)) dutA (
      .clk(clk), .rst_n(rst_n), .pix_valid(pixValid), .frame_start(frameStart),
      .layer_req(layerReq), .layer_data(layerData),
      .data(dataA), .draw(drawA), .out_valid(ovA), .layer_id(idA),
      .coll_flag(collA), .hit_mask(hmA), .last_hits(lhA)
   );

   draw_layer_mux #(.NUM_LAYERS(4), .DATA_W(6), .TRANSP_EN(0), .TRANSP_VAL(6'h3F)) dutB (
      .clk(clk), .rst_n(rst_n), .pix_valid(pixValid), .frame_start(frameStart),
      .layer_req(layerReq), .layer_data(layerData),
      .data(dataB), .draw(drawB), .out_valid(ovB), .layer_id(idB),
      .coll_flag(collB), .hit_mask(hmB), .last_hits(lhB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next expected outputs from the behavioural rules of the mux.
   function automatic exp_t stepModel(exp_t cur, logic pv, logic fs, logic [3:0] req,
                                      logic [23:0] ld, bit transpEn);
      exp_t       nxt;
      logic [3:0] elig;
      logic [5:0] colour [4];
      int         winner;
      int         count;
      bit         isColl;
      nxt    = cur;
      elig   = '0;
      winner = -1;
      count  = 0;
      for (int i = 0; i < 4; i++) begin
         colour[i] = ld[i*6 +: 6];
         elig[i]   = req[i] && !(transpEn && colour[i] == 6'h3F);
         if (elig[i]) count++;
         if (elig[i] && winner < 0) winner = i;
      end
      isColl   = pv && (count >= 2);
      nxt.ov   = pv;
      nxt.draw = pv && (winner >= 0);
      if (pv && winner >= 0) begin
         nxt.data = colour[winner];
         nxt.id   = 2'(winner);
      end
      if (fs) begin
         nxt.lh   = cur.hm;
         nxt.hm   = isColl ? elig : 4'b0000;
         nxt.coll = isColl;
      end else if (isColl) begin
         nxt.hm   = cur.hm | elig;
         nxt.coll = 1'b1;
      end
      return nxt;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) model[k] <= '{6'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0};
      end else begin
         model[0] <= stepModel(model[0], pixValid, frameStart, layerReq, layerData, 1'b1);
         model[1] <= stepModel(model[1], pixValid, frameStart, layerReq, layerData, 1'b0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      numChecks++;
      if (act === expv) numPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
   endtask

   // Per-cycle comparison on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      checkOutput("A.data",      32'(dataA), 32'(model[0].data));
      checkOutput("A.draw",      32'(drawA), 32'(model[0].draw));
      checkOutput("A.out_valid", 32'(ovA),   32'(model[0].ov));
      checkOutput("A.layer_id",  32'(idA),   32'(model[0].id));
      checkOutput("A.coll_flag", 32'(collA), 32'(model[0].coll));
      checkOutput("A.hit_mask",  32'(hmA),   32'(model[0].hm));
      checkOutput("A.last_hits", 32'(lhA),   32'(model[0].lh));
      checkOutput("B.data",      32'(dataB), 32'(model[1].data));
      checkOutput("B.draw",      32'(drawB), 32'(model[1].draw));
      checkOutput("B.out_valid", 32'(ovB),   32'(model[1].ov));
      checkOutput("B.layer_id",  32'(idB),   32'(model[1].id));
      checkOutput("B.coll_flag", 32'(collB), 32'(model[1].coll));
      checkOutput("B.hit_mask",  32'(hmB),   32'(model[1].hm));
      checkOutput("B.last_hits", 32'(lhB),   32'(model[1].lh));
   end

   // Drives one cycle of inputs, then returns just after the edge that samples them.
   task automatic applyStimulus(input logic pv, input logic fs, input logic [3:0] req,
                                input logic [5:0] d3, input logic [5:0] d2,
                                input logic [5:0] d1, input logic [5:0] d0);
      pixValid   = pv;
      frameStart = fs;
      layerReq   = req;
      layerData  = {d3, d2, d1, d0};
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".data"},      32'(dataA), 32'h0);
      checkOutput({tag, ".draw"},      32'(drawA), 32'h0);
      checkOutput({tag, ".out_valid"}, 32'(ovA),   32'h0);
      checkOutput({tag, ".layer_id"},  32'(idA),   32'h0);
      checkOutput({tag, ".coll_flag"}, 32'(collA), 32'h0);
      checkOutput({tag, ".hit_mask"},  32'(hmA),   32'h0);
      checkOutput({tag, ".last_hits"}, 32'(lhA),   32'h0);
   endtask

   initial begin
      rst_n      = 1'b0;
      pixValid   = 1'b0;
      frameStart = 1'b0;
      layerReq   = '0;
      layerData  = '0;
      @(posedge clk);
      #1;
      checkAllZero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two opaque requesters 1 and 3: layer 1 wins and a collision is logged.
      applyStimulus(1, 0, 4'b1010, 6'h11, 6'h00, 6'h05, 6'h00);
      checkOutput("v34.data",  32'(dataA), 32'h05);
      checkOutput("v34.id",    32'(idA),   32'd1);
      checkOutput("v34.draw",  32'(drawA), 32'd1);
      checkOutput("v34.hm",    32'(hmA),   32'b1010);
      checkOutput("v34.coll",  32'(collA), 32'd1);
      applyStimulus(0, 0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00);

      // Idle frame boundary, then transparent layer 0 over layer 1.
      applyStimulus(0, 1, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00);
      checkOutput("fs_idle.lh", 32'(lhA), 32'b1010);
      checkOutput("fs_idle.hm", 32'(hmA), 32'b0000);
      applyStimulus(1, 0, 4'b0011, 6'h00, 6'h00, 6'h07, 6'h3F);
      checkOutput("v35A.data", 32'(dataA), 32'h07);
      checkOutput("v35A.id",   32'(idA),   32'd1);
      checkOutput("v35A.coll", 32'(collA), 32'd0);
      checkOutput("v35A.hm",   32'(hmA),   32'b0000);
      checkOutput("v35B.data", 32'(dataB), 32'h3F);
      checkOutput("v35B.id",   32'(idB),   32'd0);
      checkOutput("v35B.hm",   32'(hmB),   32'b0011);
      checkOutput("v35B.coll", 32'(collB), 32'd1);

      // Collisions {0,2} then {1,2}, then a frame boundary with a lone requester.
      applyStimulus(0, 1, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00);
      applyStimulus(1, 0, 4'b0101, 6'h00, 6'h22, 6'h00, 6'h01);
      applyStimulus(1, 0, 4'b0110, 6'h00, 6'h23, 6'h02, 6'h00);
      checkOutput("v36.acc", 32'(hmA), 32'b0111);
      applyStimulus(1, 1, 4'b0001, 6'h00, 6'h00, 6'h00, 6'h0C);
      checkOutput("v36.lh",   32'(lhA),   32'b0111);
      checkOutput("v36.hm",   32'(hmA),   32'b0000);
      checkOutput("v36.coll", 32'(collA), 32'd0);
      checkOutput("v36.data", 32'(dataA), 32'h0C);

      // Accumulate {1,2}, then frame boundary on a colliding {0,3} pixel.
      applyStimulus(1, 0, 4'b0110, 6'h00, 6'h10, 6'h09, 6'h00);
      applyStimulus(1, 1, 4'b1001, 6'h30, 6'h00, 6'h00, 6'h2A);
      checkOutput("v37.lh",   32'(lhA),   32'b0110);
      checkOutput("v37.hm",   32'(hmA),   32'b1001);
      checkOutput("v37.coll", 32'(collA), 32'd1);

      // Back-to-back boundary: last_hits holds just the one-cycle accumulation.
      applyStimulus(1, 1, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00);
      checkOutput("b2b.lh",   32'(lhA),   32'b1001);
      checkOutput("b2b.hm",   32'(hmA),   32'b0000);
      checkOutput("b2b.coll", 32'(collA), 32'd0);
      checkOutput("b2b.data", 32'(dataA), 32'h2A);

      // Every requester transparent: nothing drawn, no collision.
      applyStimulus(1, 0, 4'b0101, 6'h00, 6'h3F, 6'h00, 6'h3F);
      checkOutput("transp.draw", 32'(drawA), 32'd0);
      checkOutput("transp.coll", 32'(collA), 32'd0);
      checkOutput("transp.data", 32'(dataA), 32'h2A);

      // Inputs wiggling without pix_valid must not disturb anything.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 4'(4'b1111 ^ i), 6'h01, 6'h02, 6'h03, 6'(i));
      end
      checkOutput("idle.draw", 32'(drawA), 32'd0);
      checkOutput("idle.ov",   32'(ovA),   32'd0);
      checkOutput("idle.data", 32'(dataA), 32'h2A);

      // Collide, then pulse reset between edges.
      applyStimulus(1, 0, 4'b0011, 6'h00, 6'h00, 6'h14, 6'h15);
      pixValid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      rst_n = 1'b1;

      // No frame boundary is needed before normal operation resumes.
      applyStimulus(1, 0, 4'b1100, 6'h1D, 6'h1E, 6'h00, 6'h00);
      checkOutput("post.data", 32'(dataA), 32'h1E);
      checkOutput("post.id",   32'(idA),   32'd2);
      checkOutput("post.coll", 32'(collA), 32'd1);
      checkOutput("post.lh",   32'(lhA),   32'b0000);

      // Mixed traffic checked only by the per-cycle model comparison.
      for (int i = 0; i < 60; i++) begin
         logic [5:0] pick [4];
         for (int j = 0; j < 4; j++) begin
            pick[j] = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
         end
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)), pick[3], pick[2], pick[1], pick[0]);
      end

      applyStimulus(0, 0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00);
      @(negedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
